// File: rtl/seg_scan_57.sv
// Eight-digit common-anode 7-segment scanner for the clock display: week day, dash, HH.MM.SS,
// with the field under edit blinking at a fixed rate.
module seg_scan_57 #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic        clk_50m_57,
  input  logic        rst_n_57,
  input  logic [23:0] time_i_57,
  input  logic [2:0]  week_day_i_57,
  input  logic [2:0]  edit_field_i_57,
  output logic [7:0]  seg_o_57,
  output logic [7:0]  an_o_57
);

  localparam int unsigned SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_q,  scan_d;
  logic [2:0]    idx_q,   idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          hidden_q, hidden_d;
  logic [2:0]    edit_q;
  logic [7:0]    seg_q,   seg_d;
  logic [7:0]    an_q,    an_d;

  logic          edit_chg_s;
  logic          field_hit_s;
  logic [7:0]    raw_seg_s;

  function automatic logic [7:0] digit_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  always_comb begin
    edit_chg_s = (edit_field_i_57 != edit_q);

    scan_d = scan_q + {{(SW-1){1'b0}}, 1'b1};
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = idx_q - 3'd1;
    end else begin
      idx_d  = idx_q;
    end

    // An edit-field change restarts the blink in the visible phase, beating a terminal count.
    blink_d  = blink_q + {{(BW-1){1'b0}}, 1'b1};
    hidden_d = hidden_q;
    if (edit_chg_s) begin
      blink_d  = '0;
      hidden_d = 1'b0;
    end else if (blink_q == BLINK_LAST) begin
      blink_d  = '0;
      hidden_d = ~hidden_q;
    end else begin
      hidden_d = hidden_q;
    end

    case (edit_field_i_57)
      3'd1:    field_hit_s = (idx_q == 3'd1) || (idx_q == 3'd0);
      3'd2:    field_hit_s = (idx_q == 3'd3) || (idx_q == 3'd2);
      3'd3:    field_hit_s = (idx_q == 3'd5) || (idx_q == 3'd4);
      3'd4:    field_hit_s = (idx_q == 3'd7);
      default: field_hit_s = 1'b0;
    endcase

    case (idx_q)
      3'd7:    raw_seg_s = (week_day_i_57 == 3'd0) ? 8'hFF : digit_code({1'b0, week_day_i_57});
      3'd6:    raw_seg_s = 8'hBF;
      3'd5:    raw_seg_s = digit_code(time_i_57[23:20]);
      3'd4:    raw_seg_s = digit_code(time_i_57[19:16]) & 8'h7F;
      3'd3:    raw_seg_s = digit_code(time_i_57[15:12]);
      3'd2:    raw_seg_s = digit_code(time_i_57[11:8]) & 8'h7F;
      3'd1:    raw_seg_s = digit_code(time_i_57[7:4]);
      3'd0:    raw_seg_s = digit_code(time_i_57[3:0]);
      default: raw_seg_s = 8'hFF;
    endcase

    // The change cycle itself already counts as visible.
    if (hidden_q && !edit_chg_s && field_hit_s) begin
      seg_d = 8'hFF;
    end else begin
      seg_d = raw_seg_s;
    end
    an_d = ~(8'd1 << idx_q);
  end

  always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
    if (!rst_n_57) begin
      scan_q   <= '0;
      idx_q    <= 3'd7;
      blink_q  <= '0;
      hidden_q <= 1'b0;
      edit_q   <= 3'd0;
      seg_q    <= 8'hFF;
      an_q     <= 8'hFF;
    end else begin
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      blink_q  <= blink_d;
      hidden_q <= hidden_d;
      edit_q   <= edit_field_i_57;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg_o_57 = seg_q;
  assign an_o_57  = an_q;

endmodule
